// File: rtl/pattern_check_pkg.sv
// rtl/pattern_check_pkg.sv - shared FSM encodings and defaults for the pattern checker
package pattern_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // 0.5 s of silence at 50 MHz
    localparam int DEFAULT_TIMEOUT = 25_000_000;

endpackage

// File: rtl/pattern_check_sat_counter.sv
// rtl/pattern_check_sat_counter.sv - increment-with-saturate counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pattern_check.sv
// rtl/pattern_check.sv - incrementing-pattern checker with sticky error flag and stall timeout
module pattern_check
    import pattern_check_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              chk_en,
    input  logic              err_clr,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              locked,
    output logic              error_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(TIMEOUT);

    state_t            state;
    logic              s1_vld;
    logic [DATA_W-1:0] s1_din;
    logic [DATA_W-1:0] exp_word;
    logic [SW-1:0]     stall_cnt;

    logic active;
    logic in_lock;
    logic mismatch;
    logic stall_hit;

    // err_clr and chk_en=0 both suppress any compare result in the same cycle
    assign active    = chk_en && !err_clr;
    assign in_lock   = (state == ST_LOCK) && active;
    assign mismatch  = in_lock && s1_vld && (s1_din != exp_word);
    assign stall_hit = in_lock && !s1_vld && (stall_cnt == STALL_LAST);
    assign locked    = (state == ST_LOCK);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state      <= ST_IDLE;
            s1_vld     <= 1'b0;
            s1_din     <= '0;
            exp_word   <= '0;
            stall_cnt  <= '0;
            error_flag <= 1'b0;
            word_cnt   <= '0;
        end else begin
            s1_vld <= din_vld && active;
            s1_din <= din;
            if (err_clr) begin
                error_flag <= 1'b0;
                word_cnt   <= '0;
                stall_cnt  <= '0;
                state      <= chk_en ? ST_SYNC : ST_IDLE;
            end else if (!chk_en) begin
                stall_cnt <= '0;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SYNC;
                    ST_SYNC: begin
                        stall_cnt <= '0;
                        if (s1_vld) begin
                            exp_word <= s1_din + DATA_W'(1);
                            state    <= ST_LOCK;
                        end
                    end
                    ST_LOCK: begin
                        if (s1_vld) begin
                            // on a match s1_din equals exp_word; on a mismatch this resyncs
                            exp_word  <= s1_din + DATA_W'(1);
                            word_cnt  <= word_cnt + CNT_W'(1);
                            stall_cnt <= '0;
                            if (mismatch) error_flag <= 1'b1;
                        end else if (stall_cnt != STALL_MAX) begin
                            stall_cnt <= stall_cnt + SW'(1);
                            if (stall_hit) error_flag <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk_50m),
        .rst (rst),
        .clr (err_clr),
        .inc (mismatch || stall_hit),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_pattern_check.sv
// tb/tb_pattern_check.sv - self-checking bench for pattern_check
module tb_pattern_check;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int TO = 100;

    logic          clk_50m = 1'b0;
    logic          rst     = 1'b1;
    logic          chk_en  = 1'b0;
    logic          err_clr = 1'b0;
    logic          din_vld = 1'b0;
    logic [DW-1:0] din     = '0;
    logic          locked;
    logic          error_flag;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] word_cnt;

    always #10 clk_50m = ~clk_50m;

    pattern_check #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .chk_en     (chk_en),
        .err_clr    (err_clr),
        .din_vld    (din_vld),
        .din        (din),
        .locked     (locked),
        .error_flag (error_flag),
        .err_cnt    (err_cnt),
        .word_cnt   (word_cnt)
    );

    int checks = 0;
    int errors = 0;

    // reference: mode 0 off, 1 hunting for a seed, 2 tracking; words reach the checker one cycle late
    int            m_mode;
    bit            m_pv;
    logic [DW-1:0] m_pd;
    logic [DW-1:0] m_exp;
    bit            m_flag;
    int            m_errs;
    int            m_words;
    int            m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit clr, input bit vld, input logic [DW-1:0] d);
        if (r) begin
            m_mode = 0; m_pv = 0; m_pd = '0; m_exp = '0;
            m_flag = 0; m_errs = 0; m_words = 0; m_idle = 0;
            return;
        end
        if (clr) begin
            m_flag = 0; m_errs = 0; m_words = 0; m_idle = 0;
            m_mode = en ? 1 : 0;
        end else if (!en) begin
            m_mode = 0;
            m_idle = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_pv) begin
                m_exp  = m_pd + 16'd1;
                m_mode = 2;
                m_idle = 0;
            end
        end else begin
            if (m_pv) begin
                m_words++;
                if (m_pd !== m_exp) begin
                    m_flag = 1;
                    m_errs++;
                end
                m_exp  = m_pd + 16'd1;
                m_idle = 0;
            end else if (m_idle < TO) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_flag = 1;
                    m_errs++;
                end
            end
        end
        m_pv = vld && en && !clr;
        m_pd = d;
    endtask

    task automatic cycle(input bit r, input bit en, input bit clr, input bit vld, input logic [DW-1:0] d);
        logic [DW-1:0] words_mod;
        rst = r; chk_en = en; err_clr = clr; din_vld = vld; din = d;
        @(posedge clk_50m);
        model_step(r, en, clr, vld, d);
        @(negedge clk_50m);
        words_mod = m_words[DW-1:0];
        check("locked", locked, m_mode == 2);
        check("error_flag", error_flag, m_flag);
        check("err_cnt", err_cnt, (m_errs > 65535) ? 65535 : m_errs);
        check("word_cnt", word_cnt, words_mod);
    endtask

    typedef struct {
        bit            r, en, clr, vld;
        logic [DW-1:0] d;
        bit            lk, fl;
        logic [CW-1:0] ec, wc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 16'd0,   0, 0, 16'd0, 16'd0};
        tbl[1]  = '{0, 1, 0, 1, 16'd5,   0, 0, 16'd0, 16'd0};
        tbl[2]  = '{0, 1, 0, 1, 16'd6,   1, 0, 16'd0, 16'd0};
        tbl[3]  = '{0, 1, 0, 1, 16'd7,   1, 0, 16'd0, 16'd1};
        tbl[4]  = '{0, 1, 0, 1, 16'd9,   1, 0, 16'd0, 16'd2};
        tbl[5]  = '{0, 1, 0, 1, 16'd10,  1, 1, 16'd1, 16'd3};
        tbl[6]  = '{0, 1, 0, 0, 16'd0,   1, 1, 16'd1, 16'd4};
        tbl[7]  = '{0, 1, 0, 0, 16'd0,   1, 1, 16'd1, 16'd4};
        tbl[8]  = '{0, 1, 1, 1, 16'd77,  0, 0, 16'd0, 16'd0};
        tbl[9]  = '{0, 1, 0, 1, 16'd100, 0, 0, 16'd0, 16'd0};
        tbl[10] = '{0, 1, 0, 1, 16'd101, 1, 0, 16'd0, 16'd0};
        tbl[11] = '{0, 0, 0, 1, 16'd102, 0, 0, 16'd0, 16'd0};
        tbl[12] = '{0, 0, 0, 0, 16'd0,   0, 0, 16'd0, 16'd0};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].r, tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].d);
            check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            check($sformatf("tbl%0d_flag", i), error_flag, tbl[i].fl);
            check($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].ec);
            check($sformatf("tbl%0d_word_cnt", i), word_cnt, tbl[i].wc);
        end

        // clean 0..99 stream
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) cycle(0, 1, 0, 1, 16'(i));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("clean_word_cnt", word_cnt, 99);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_flag", error_flag, 0);
        check("clean_locked", locked, 1);

        // corrupt word 10
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i <= 20; i++) cycle(0, 1, 0, 1, (i == 10) ? 16'h00AA : 16'(i));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("corrupt_flag", error_flag, 1);
        check("corrupt_word_cnt", word_cnt, 20);

        // wrap-around stream
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 16'hFFFC + 16'(i));
        cycle(0, 1, 0, 0, 0);
        check("wrap_word_cnt", word_cnt, 9);
        check("wrap_flag", error_flag, 0);
        check("wrap_err_cnt", err_cnt, 0);

        // stall timeout fires once
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 16'd0);
        cycle(0, 1, 0, 1, 16'd1);
        for (int i = 0; i < 600; i++) cycle(0, 1, 0, 0, 0);
        check("stall_flag", error_flag, 1);
        check("stall_err_cnt", err_cnt, 1);
        check("stall_locked", locked, 1);

        // err_clr with a coincident bad word, then relock on 50
        cycle(0, 1, 1, 1, 16'h1234);
        for (int i = 50; i <= 60; i++) cycle(0, 1, 0, 1, 16'(i));
        cycle(0, 1, 0, 0, 0);
        check("clr_flag", error_flag, 0);
        check("clr_err_cnt", err_cnt, 0);
        check("clr_word_cnt", word_cnt, 10);

        // reset mid-stream, then a dropped word and chk_en low
        for (int i = 200; i < 206; i++) cycle(0, 1, 0, 1, 16'(i));
        cycle(1, 1, 0, 1, 16'd206);
        check("rst_locked", locked, 0);
        check("rst_word_cnt", word_cnt, 0);
        for (int i = 0; i <= 10; i++) if (i != 5) cycle(0, 1, 0, 1, 16'(i));
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 16'(i + 11));
        check("hold_locked", locked, 0);
        check("hold_word_cnt", word_cnt, 9);
        check("hold_err_cnt", err_cnt, 1);
        check("hold_flag", error_flag, 1);

        // randomized traffic against the reference
        begin
            logic [DW-1:0] next_w;
            int burst;
            next_w = 16'($urandom);
            burst  = 0;
            for (int i = 0; i < 4000; i++) begin
                if (burst > 0) begin
                    burst--;
                    cycle(0, 1, 0, 0, 0);
                end else begin
                    bit r, en, clr, vld;
                    logic [DW-1:0] d;
                    int sel;
                    if ($urandom_range(0, 299) == 0) burst = 150;
                    r   = ($urandom_range(0, 999) < 3);
                    en  = ($urandom_range(0, 99) >= 2);
                    clr = ($urandom_range(0, 199) == 0);
                    vld = ($urandom_range(0, 9) < 7);
                    sel = $urandom_range(0, 99);
                    if (sel < 2) begin
                        d = 16'($urandom);
                    end else begin
                        if (sel < 4) next_w = next_w + 16'd1;
                        d = next_w;
                    end
                    if (vld) next_w = next_w + 16'd1;
                    cycle(r, en, clr, vld, d);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
